ultra_sonic_echo_emulator: RTL

Cycle-accurate stand-in for the HC-SR04 ultrasonic sensor: it receives the `trigger` pulse driven by `avalon_distance_module_interface` and answers with an `echo` pulse whose width comes from a Nios-writable register. It sits on the same memory-mapped I/O bus as the distance module and replaces the physical sensor in hardware-in-loop runs and system benches. Measured distances can then be checked end to end against a programmed echo width.

---
 rtl/ultra_sonic_echo_emulator.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ultra_sonic_echo_emulator.sv
// HC-SR04 ultrasonic sensor stand-in.
// It qualifies a trigger pulse and answers with an echo pulse whose width comes
// from a bus-writable register. Usage counters are exposed on the same bus.
module ultra_sonic_echo_emulator #(
  parameter int unsigned TRIG_MIN_CYCLES   = 500,
  parameter int unsigned ECHO_DELAY_CYCLES = 1500,
  parameter int unsigned MAX_ECHO_CYCLES   = 1900000,
  parameter int unsigned HOLDOFF_CYCLES    = 3000000,
  parameter logic [15:0] ADDR_BASE         = 16'h0A00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_select,
  input  logic        write_en,
  input  logic [15:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic        trigger,
  output logic        echo
);

  localparam int unsigned WIDTH_W = 22;
  localparam logic [WIDTH_W-1:0] WIDTH_RST = WIDTH_W'(29000);
  localparam logic [31:0] MAX_ECHO_W  = 32'(MAX_ECHO_CYCLES);
  localparam logic [31:0] TRIG_MIN_W  = 32'(TRIG_MIN_CYCLES);
  localparam logic [31:0] DELAY_W     = 32'(ECHO_DELAY_CYCLES);
  localparam logic [31:0] HOLDOFF_W   = 32'(HOLDOFF_CYCLES);
  localparam logic [15:0] ADDR_WIDTH  = ADDR_BASE;
  localparam logic [15:0] ADDR_CTRL   = ADDR_BASE + 16'd1;
  localparam logic [15:0] ADDR_TRIGC  = ADDR_BASE + 16'd2;
  localparam logic [15:0] ADDR_SHORTC = ADDR_BASE + 16'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_DELAY,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  state_t             r_state;
  logic               r_sync1;
  logic               r_trig_s;
  logic               r_trig_d;
  logic [31:0]        r_hi_cnt;
  logic [31:0]        r_cnt;
  logic [31:0]        r_eff_w;
  logic [WIDTH_W-1:0] r_width;
  logic               r_enable;
  logic               r_no_target;
  logic [15:0]        r_trig_count;
  logic [7:0]         r_short_count;
  logic [31:0]        r_read_data;
  logic               r_echo;

  logic               w_wr;
  logic               w_rd;
  logic [31:0]        w_eff_w;
  logic               w_unused;

  assign w_wr      = io_select & write_en;
  assign w_rd      = io_select & ~write_en;
  assign w_unused  = &{1'b0, write_data[31:WIDTH_W]};
  assign read_data = r_read_data;
  assign echo      = r_echo;

  // Echo width to latch on DELAY entry: no-target or zero width means full ceiling.
  always_comb begin
    w_eff_w = MAX_ECHO_W;
    if (!r_no_target && (r_width != '0) && (32'(r_width) < MAX_ECHO_W)) begin
      w_eff_w = 32'(r_width);
    end
  end

  // Two-flop trigger synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_trig_s <= 1'b0;
      r_trig_d <= 1'b0;
    end else begin
      r_sync1  <= trigger;
      r_trig_s <= r_sync1;
      r_trig_d <= r_trig_s;
    end
  end

  // Writable configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_width     <= WIDTH_RST;
      r_enable    <= 1'b1;
      r_no_target <= 1'b0;
    end else if (w_wr) begin
      case (address)
        ADDR_WIDTH: r_width <= write_data[WIDTH_W-1:0];
        ADDR_CTRL: begin
          r_enable    <= write_data[0];
          r_no_target <= write_data[1];
        end
        default: ;
      endcase
    end
  end

  // Registered read port; data holds until the next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_read_data <= '0;
    end else if (w_rd) begin
      case (address)
        ADDR_WIDTH:  r_read_data <= 32'(r_width);
        ADDR_CTRL:   r_read_data <= {30'd0, r_no_target, r_enable};
        ADDR_TRIGC:  r_read_data <= 32'(r_trig_count);
        ADDR_SHORTC: r_read_data <= 32'(r_short_count);
        default:     r_read_data <= '0;
      endcase
    end
  end

  // Measurement FSM: qualify trigger, delay, emit echo, then hold off.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_hi_cnt      <= '0;
      r_cnt         <= '0;
      r_eff_w       <= '0;
      r_echo        <= 1'b0;
      r_trig_count  <= '0;
      r_short_count <= '0;
    end else if (!r_enable) begin
      r_state  <= S_IDLE;
      r_echo   <= 1'b0;
      r_cnt    <= '0;
      r_hi_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_trig_s && !r_trig_d) begin
            r_state  <= S_TRIG;
            r_hi_cnt <= 32'd1;
          end
        end
        S_TRIG: begin
          if (r_trig_s) begin
            if (r_hi_cnt != '1) r_hi_cnt <= r_hi_cnt + 32'd1;
          end else if (r_hi_cnt >= TRIG_MIN_W) begin
            r_state      <= S_DELAY;
            r_cnt        <= '0;
            r_eff_w      <= w_eff_w;
            r_trig_count <= r_trig_count + 16'd1;
          end else begin
            r_state <= S_IDLE;
            if (r_short_count != 8'hFF) r_short_count <= r_short_count + 8'd1;
          end
        end
        S_DELAY: begin
          if (r_cnt == DELAY_W) begin
            r_state <= S_ECHO;
            r_echo  <= 1'b1;
            r_cnt   <= 32'd1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_ECHO: begin
          if (r_cnt == r_eff_w) begin
            r_state <= S_HOLDOFF;
            r_echo  <= 1'b0;
            r_cnt   <= 32'd1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_HOLDOFF: begin
          if (r_cnt >= HOLDOFF_W) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
